imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the riscv core.
//
// Accepts a framed byte stream (LEN_LO, LEN_HI, N*4 data bytes, CHK) on a
// valid/ready interface, assembles little-endian 32-bit words and writes
// them to consecutive instruction-memory word addresses. The core is held
// in reset until a frame completes with a matching XOR checksum.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      one-cycle pulse arming a new load (ignored mid-load)
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte (transfer = in_valid && in_ready)
//   imem_we    instruction-memory write strobe, one cycle per word
//   imem_addr  word address of the write
//   imem_wdata word to write
//   cpu_hold   1 = keep the core in reset
//   done       load finished and verified (level)
//   error      load aborted (level)
module imem_loader #(
    parameter int PROG_SIZE = 20,
    parameter int ADDR_W    = $clog2(PROG_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;

    localparam logic [15:0] MAX_WORDS = 16'(PROG_SIZE);

    state_t      state;
    logic [15:0] len;
    logic [15:0] widx;
    logic [1:0]  bidx;
    logic [23:0] acc;
    logic [7:0]  chk;
    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = in_valid && in_ready;
    // Full word count as it becomes known on the LEN_HI transfer.
    assign len_full = {in_data, len[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= 16'd0;
            widx       <= 16'd0;
            bidx       <= 2'd0;
            acc        <= 24'd0;
            chk        <= 8'd0;
        end else begin
            // Write strobe is a single-cycle pulse; nothing back-pressures it.
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN0;
                        in_ready  <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        cpu_hold  <= 1'b1;
                        chk       <= 8'd0;
                        len       <= 16'd0;
                        widx      <= 16'd0;
                        bidx      <= 2'd0;
                        imem_addr <= '0;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        chk      <= chk ^ in_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        chk       <= chk ^ in_data;
                        // Oversize frames are rejected before any write, so
                        // the address can never run past the memory.
                        if (len_full > MAX_WORDS) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk  <= chk ^ in_data;
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: acc[7:0]   <= in_data;
                            2'd1: acc[15:8]  <= in_data;
                            2'd2: acc[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= widx[ADDR_W-1:0];
                                imem_wdata <= {in_data, acc};
                                widx       <= widx + 16'd1;
                                if (widx + 16'd1 == len)
                                    state <= CHK;
                            end
                        endcase
                    end
                end
                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int PS = 20;
    localparam int AW = $clog2(PS);

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_loader #(.PROG_SIZE(PS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_words[$];
    bit          exp_done;
    bit          exp_err;
    int          byte_cyc[$];

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe observed mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    // Reference: interpret the frame directly from its format rules.
    task automatic model();
        int n;
        logic [7:0] x;
        longint w;
        exp_words.delete();
        exp_done = 0;
        exp_err  = 0;
        n = int'(frame[0]) + 256 * int'(frame[1]);
        if (n > PS) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = longint'(frame[2+4*i]) + 256 * longint'(frame[3+4*i])
              + 65536 * longint'(frame[4+4*i]) + 16777216 * longint'(frame[5+4*i]);
            exp_words.push_back(32'(w));
        end
        x = 8'd0;
        for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
        if (frame[frame.size()-1] == x) exp_done = 1;
        else exp_err = 1;
    endtask

    task automatic build(input int n, input bit good);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
        x = 8'd0;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic run_frame(input int gap, input bit rgap, input int mid_start);
        pulse_start();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        byte_cyc.delete();
        foreach (frame[i]) begin
            if (i == mid_start) pulse_start();
            send_byte(frame[i]);
            byte_cyc.push_back(cyc);
            if (i != frame.size() - 1) idle(rgap ? $urandom_range(0, gap) : gap);
        end
    endtask

    task automatic verify(input string tag);
        int m;
        model();
        check({tag, ".nwr"}, 32'(wr_addr.size()), 32'(exp_words.size()));
        m = (wr_addr.size() < exp_words.size()) ? wr_addr.size() : exp_words.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("%s.data%0d", tag, i), wr_data[i], exp_words[i]);
            check($sformatf("%s.lat%0d", tag, i), 32'(wr_cyc[i]), 32'(byte_cyc[5+4*i]));
        end
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".error"}, 32'(error), 32'(exp_err));
        check({tag, ".hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({tag, ".ready"}, 32'(in_ready), 32'd0);
        check({tag, ".we"}, 32'(imem_we), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(in_ready), 32'd0);
        check({tag, ".we"}, 32'(imem_we), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".error"}, 32'(error), 32'd0);
        check({tag, ".addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".wdata"}, imem_wdata, 32'd0);
        check({tag, ".hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);
        check("idle.ready", 32'(in_ready), 32'd0);

        // Two-word load
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h63};
        run_frame(0, 0, -1);
        verify("s1");
        check("s1.w0", (wr_data.size() > 0) ? wr_data[0] : 32'hDEADBEEF, 32'h00500093);
        check("s1.w1", (wr_data.size() > 1) ? wr_data[1] : 32'hDEADBEEF, 32'h00108133);
        check("s1.done_const", 32'(done), 32'd1);
        check("s1.hold_const", 32'(cpu_hold), 32'd0);

        // Bad checksum
        frame[10] = 8'h64;
        run_frame(0, 0, -1);
        verify("s2");
        check("s2.error_const", 32'(error), 32'd1);

        // Oversize, then bytes offered in ERR must be ignored
        frame = '{8'h15, 8'h00};
        run_frame(0, 0, -1);
        verify("s3");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        idle(3);
        in_valid = 1'b0;
        check("s3.nwr_after", 32'(wr_addr.size()), 32'd0);
        check("s3.error_after", 32'(error), 32'd1);

        frame = '{8'hFF, 8'hFF};
        run_frame(0, 0, -1);
        verify("s3b");

        // Empty frame, then start in DONE
        frame = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 0, -1);
        verify("s4");
        pulse_start();
        check("s4.restart_done", 32'(done), 32'd0);
        check("s4.restart_hold", 32'(cpu_hold), 32'd1);
        check("s4.restart_ready", 32'(in_ready), 32'd1);

        // Gapped stream (start issued while still in LEN0 is ignored)
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h63};
        run_frame(3, 0, -1);
        verify("s5a");

        // Reset after the 5th byte
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        #2 rst = 1'b0;
        #1 check_reset_outputs("s5.rst");
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check("s5.ready_after", 32'(in_ready), 32'd0);
        check("s5.hold_after", 32'(cpu_hold), 32'd1);
        run_frame(0, 0, -1);
        verify("s5b");

        // Start pulse while in DATA
        run_frame(0, 0, 6);
        verify("s6");

        // Maximum-size frame
        build(PS, 1);
        run_frame(1, 1, -1);
        verify("max");

        // Randomised frames with random gaps
        for (int k = 0; k < 6; k++) begin
            build($urandom_range(1, PS), bit'($urandom_range(0, 1)));
            run_frame(2, 1, -1);
            verify($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
